regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised integer register file with a built-in busy-bit scoreboard for the pipelined core. It sits between decode and execute. Source indices are taken straight from the fetched instruction word, and both operands plus their hazard status are returned one clock later. Writeback writes through a single port. Issue marks destination registers pending, and the matching writeback clears them, so decode can stall on RAW hazards without a separate hazard unit.

## Interface
- XLEN, 32, data width of each register
- NREGS, 32, number of architectural registers; power of two, 2..32
- AW, $clog2(NREGS), register index width; derived, do not override
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-high
- instruction  in  32  instruction word; rs1 = [19:15], rs2 = [24:20], truncated to AW bits
- rd_en  in  1  read strobe; outputs update only when high
- rs1_data  out  XLEN  registered read data, source 1
- rs2_data  out  XLEN  registered read data, source 2
- rs1_busy  out  1  registered: source 1 has a pending writer
- rs2_busy  out  1  registered: source 2 has a pending writer
- issue_en  in  1  mark destination register pending
- issue_rd  in  AW  destination index being issued
- wen  in  1  writeback enable
- waddr  in  AW  writeback index
- wdata  in  XLEN  writeback data

## Operation
- Storage: NREGS x XLEN array. On rst, every register is 0, every busy bit is 0, and rs1_data, rs2_data, rs1_busy, rs2_busy are all 0.
- Register 0 is hardwired:
  - it reads as 0 and is never busy;
  - writes to it are dropped;
  - issue to it is dropped.
- Write: on a clock edge with wen=1 and waddr!=0, the array entry is set to wdata.
- Read: on a clock edge with rd_en=1, rsN_data gets the array entry and rsN_busy gets the busy bit, using the pre-edge state. When rd_en=0, all four outputs hold their values.
- Scoreboard, per register r!=0, evaluated on each edge:
  - busy is set if issue_en and issue_rd==r;
  - otherwise busy is cleared if wen and waddr==r;
  - otherwise busy holds.
  - When issue and writeback hit the same register in the same cycle, issue wins: a new producer supersedes the retiring one.
- Writeback to a register that is not busy is legal: data is written and busy stays 0.
- Reset asserted mid-operation: the array, busy bits and outputs clear immediately, without waiting for a clock edge. Any pending issue or write in that cycle is lost.

## Timing
- Read latency is 1 cycle, from an instruction/rd_en edge to valid rsN_data/rsN_busy.
- A write becomes architecturally visible at the edge where wen is sampled.
- The same-cycle read-during-write result depends on REGFILE_BYPASS_EN (see Configuration).
- A busy bit set at edge N is visible on a read sampled at edge N+1 or later.
- Throughput: one read pair, one issue and one write are accepted every cycle.

## Configuration
- REGFILE_BYPASS_EN defined: write-first forwarding is enabled. When rd_en=1, wen=1 and waddr==rsN!=0 in the same cycle:
  - rsN_data gets wdata;
  - rsN_busy gets the post-edge busy value, which is 0 unless issue_rd==rsN in that same cycle.
- REGFILE_BYPASS_EN undefined: read-first behaviour. In that same case:
  - rsN_data gets the old array value;
  - rsN_busy gets the pre-edge busy bit.
  - Decode must then wait one extra cycle after writeback.

## Test plan
- Reset: pulse rst asynchronously, then read x1..x31 -> all data 0, all busy 0. Outputs drop to 0 without waiting for a clock edge.
- x0 protection: wen=1, waddr=0, wdata=0xDEADBEEF, plus issue_rd=0; then read rs1=0 -> rs1_data=0, rs1_busy=0.
- Basic write and read: write x5=0x12345678, next cycle read rs1=5, rs2=5 -> both outputs 0x12345678 one cycle later.
- Scoreboard:
  - issue_rd=7, then read rs2=7 -> rs2_busy=1;
  - writeback x7=0xA5A5A5A5, then read -> rs2_busy=0, data=0xA5A5A5A5;
  - issue_rd=7 and wen/waddr=7 in the same cycle -> busy remains 1.
- Read-during-write: x9 holds 0x1; write x9=0x2 while reading rs1=9 -> rs1_data=0x2 with REGFILE_BYPASS_EN, 0x1 without it.
- Hold and parameters: rd_en=0 while the instruction changes -> outputs unchanged. Repeat the suite with XLEN=64, NREGS=16; with NREGS=16, index bit 4 is ignored, so rs1=21 reads x5.

Source files
------------

// File: rtl/regfile_sb.sv
// regfile_sb: integer register file with a busy-bit scoreboard and 1-cycle registered reads.
// Define REGFILE_BYPASS_EN for write-first forwarding; the default build is read-first.
module regfile_sb #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     instruction,
  input  logic            rd_en,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            issue_en,
  input  logic [AW-1:0]   issue_rd,
  input  logic            wen,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata
);

  logic [XLEN-1:0] regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;

  logic [AW-1:0] rs1;
  logic [AW-1:0] rs2;
  logic          wr_hit1;
  logic          wr_hit2;
  logic [XLEN-1:0] rd1_data;
  logic [XLEN-1:0] rd2_data;
  logic          rd1_busy;
  logic          rd2_busy;
  logic          unused_bits;

  // Only the low AW bits of each source field address the array.
  assign rs1 = instruction[15 +: AW];
  assign rs2 = instruction[20 +: AW];
  assign unused_bits = ^instruction;

  assign wr_hit1 = wen && (waddr == rs1) && (rs1 != '0);
  assign wr_hit2 = wen && (waddr == rs2) && (rs2 != '0);

  // Issue takes priority so a new producer supersedes a retiring one.
  always_comb begin
    busy_nxt = busy;
    busy_nxt[0] = 1'b0;
    for (int r = 1; r < NREGS; r++) begin
      if (issue_en && issue_rd == AW'(r)) begin
        busy_nxt[r] = 1'b1;
      end else if (wen && waddr == AW'(r)) begin
        busy_nxt[r] = 1'b0;
      end
    end
  end

`ifdef REGFILE_BYPASS_EN
  assign rd1_data = wr_hit1 ? wdata : regs[rs1];
  assign rd2_data = wr_hit2 ? wdata : regs[rs2];
  assign rd1_busy = wr_hit1 ? busy_nxt[rs1] : busy[rs1];
  assign rd2_busy = wr_hit2 ? busy_nxt[rs2] : busy[rs2];
`else
  assign rd1_data = regs[rs1];
  assign rd2_data = regs[rs2];
  assign rd1_busy = busy[rs1];
  assign rd2_busy = busy[rs2];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        regs[r] <= '0;
      end
    end else if (wen && waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs1_data <= '0;
      rs2_data <= '0;
      rs1_busy <= 1'b0;
      rs2_busy <= 1'b0;
    end else if (rd_en) begin
      rs1_data <= rd1_data;
      rs2_data <= rd2_data;
      rs1_busy <= rd1_busy;
      rs2_busy <= rd2_busy;
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed vector table plus hand sequences for reset,
// scoreboard and a 64-bit, 16-entry instance.
module tb_regfile_sb;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instruction;
  logic        rd_en;
  logic [31:0] rs1_data, rs2_data;
  logic        rs1_busy, rs2_busy;
  logic        issue_en;
  logic [4:0]  issue_rd;
  logic        wen;
  logic [4:0]  waddr;
  logic [31:0] wdata;

  logic [31:0] b_instruction;
  logic        b_rd_en;
  logic [63:0] b_rs1_data, b_rs2_data;
  logic        b_rs1_busy, b_rs2_busy;
  logic        b_issue_en;
  logic [3:0]  b_issue_rd;
  logic        b_wen;
  logic [3:0]  b_waddr;
  logic [63:0] b_wdata;

  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  regfile_sb dut (
    .clk(clk), .rst(rst), .instruction(instruction), .rd_en(rd_en),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .issue_en(issue_en), .issue_rd(issue_rd),
    .wen(wen), .waddr(waddr), .wdata(wdata)
  );

  regfile_sb #(.XLEN(64), .NREGS(16)) dut16 (
    .clk(clk), .rst(rst), .instruction(b_instruction), .rd_en(b_rd_en),
    .rs1_data(b_rs1_data), .rs2_data(b_rs2_data),
    .rs1_busy(b_rs1_busy), .rs2_busy(b_rs2_busy),
    .issue_en(b_issue_en), .issue_rd(b_issue_rd),
    .wen(b_wen), .waddr(b_waddr), .wdata(b_wdata)
  );

  typedef struct {
    logic        rd;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        ie;
    logic [4:0]  ird;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] e1;
    logic [31:0] e2;
    logic        b1;
    logic        b2;
  } vec_t;

  vec_t tv [20];

  function automatic vec_t mk(logic rd, logic [4:0] r1, logic [4:0] r2,
                              logic ie, logic [4:0] ird,
                              logic we, logic [4:0] wa, logic [31:0] wd,
                              logic [31:0] e1, logic [31:0] e2,
                              logic b1, logic b2);
    vec_t v;
    v.rd = rd; v.r1 = r1; v.r2 = r2; v.ie = ie; v.ird = ird;
    v.we = we; v.wa = wa; v.wd = wd;
    v.e1 = e1; v.e2 = e2; v.b1 = b1; v.b2 = b2;
    return v;
  endfunction

  function automatic logic [31:0] ins(logic [4:0] r1, logic [4:0] r2);
    return {7'h55, r2, r1, 15'h1abc};
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_en = 1'b0; issue_en = 1'b0; issue_rd = '0;
    wen = 1'b0; waddr = '0; wdata = '0;
    b_rd_en = 1'b0; b_issue_en = 1'b0; b_issue_rd = '0;
    b_wen = 1'b0; b_waddr = '0; b_wdata = '0;
  endtask

  initial begin
    tv[0]  = mk(1, 0, 0, 1, 0, 1, 0, 32'hDEADBEEF, 0, 0, 0, 0);
    tv[1]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tv[2]  = mk(0, 5, 5, 0, 0, 1, 5, 32'h12345678, 0, 0, 0, 0);
    tv[3]  = mk(1, 5, 5, 0, 0, 0, 0, 0, 32'h12345678, 32'h12345678, 0, 0);
    tv[4]  = mk(1, 5, 7, 1, 7, 0, 0, 0, 32'h12345678, 0, 0, 0);
    tv[5]  = mk(1, 5, 7, 0, 0, 0, 0, 0, 32'h12345678, 0, 0, 1);
    tv[6]  = mk(1, 0, 7, 0, 0, 1, 7, 32'hA5A5A5A5,
                0, BYP ? 32'hA5A5A5A5 : 32'h0, 0, BYP ? 1'b0 : 1'b1);
    tv[7]  = mk(1, 0, 7, 0, 0, 0, 0, 0, 0, 32'hA5A5A5A5, 0, 0);
    tv[8]  = mk(1, 3, 7, 1, 7, 1, 7, 32'h11111111,
                0, BYP ? 32'h11111111 : 32'hA5A5A5A5, 0, BYP);
    tv[9]  = mk(1, 3, 7, 0, 0, 0, 0, 0, 0, 32'h11111111, 0, 1);
    tv[10] = mk(0, 9, 9, 0, 0, 1, 9, 32'h1, 0, 32'h11111111, 0, 1);
    tv[11] = mk(1, 9, 7, 0, 0, 1, 9, 32'h2,
                BYP ? 32'h2 : 32'h1, 32'h11111111, 0, 1);
    tv[12] = mk(1, 9, 9, 0, 0, 0, 0, 0, 32'h2, 32'h2, 0, 0);
    tv[13] = mk(0, 5, 5, 0, 0, 0, 0, 0, 32'h2, 32'h2, 0, 0);
    tv[14] = mk(0, 5, 5, 0, 0, 1, 7, 32'h22222222, 32'h2, 32'h2, 0, 0);
    tv[15] = mk(1, 7, 5, 0, 0, 0, 0, 0, 32'h22222222, 32'h12345678, 0, 0);
    tv[16] = mk(1, 31, 5, 0, 0, 1, 5, 32'h55,
                0, BYP ? 32'h55 : 32'h12345678, 0, 0);
    tv[17] = mk(1, 5, 31, 0, 0, 0, 0, 0, 32'h55, 0, 0, 0);
    tv[18] = mk(0, 1, 2, 1, 31, 0, 0, 0, 32'h55, 0, 0, 0);
    tv[19] = mk(1, 5, 31, 0, 0, 0, 0, 0, 32'h55, 0, 0, 1);

    instruction = '0;
    b_instruction = '0;
    idle();
    step();
    step();
    rst = 1'b0;
    chk("reset rs1_data", {32'h0, rs1_data}, 64'h0);
    chk("reset rs2_data", {32'h0, rs2_data}, 64'h0);
    chk("reset busy", {62'h0, rs1_busy, rs2_busy}, 64'h0);

    for (int i = 0; i < 20; i++) begin
      instruction = ins(tv[i].r1, tv[i].r2);
      rd_en = tv[i].rd;
      issue_en = tv[i].ie; issue_rd = tv[i].ird;
      wen = tv[i].we; waddr = tv[i].wa; wdata = tv[i].wd;
      step();
      chk($sformatf("vec%0d rs1_data", i), {32'h0, rs1_data}, {32'h0, tv[i].e1});
      chk($sformatf("vec%0d rs2_data", i), {32'h0, rs2_data}, {32'h0, tv[i].e2});
      chk($sformatf("vec%0d busy", i), {62'h0, rs1_busy, rs2_busy},
          {62'h0, tv[i].b1, tv[i].b2});
    end

    // Mid-cycle asynchronous reset with a write and issue pending.
    rd_en = 1'b1; instruction = ins(5, 31);
    wen = 1'b1; waddr = 5'd3; wdata = 32'hCAFE0001;
    issue_en = 1'b1; issue_rd = 5'd4;
    #2;
    rst = 1'b1;
    #1;
    chk("async rst data", {rs1_data, rs2_data}, 64'h0);
    chk("async rst busy", {62'h0, rs1_busy, rs2_busy}, 64'h0);
    step();
    rst = 1'b0;
    idle();
    for (int i = 1; i < 32; i++) begin
      rd_en = 1'b1;
      instruction = ins(5'(i), 5'(i));
      step();
      chk($sformatf("post-rst x%0d", i),
          {rs1_data, rs2_data} | {62'h0, rs1_busy, rs2_busy}, 64'h0);
    end

    // Hold: changing instruction with rd_en low.
    idle();
    wen = 1'b1; waddr = 5'd6; wdata = 32'h600D600D;
    step();
    wen = 1'b0; rd_en = 1'b1; instruction = ins(6, 6);
    step();
    rd_en = 1'b0; instruction = ins(1, 2);
    step();
    step();
    chk("hold data", {rs1_data, rs2_data}, {32'h600D600D, 32'h600D600D});

    // 64-bit, 16-entry instance; index bit 4 is ignored.
    idle();
    b_wen = 1'b1; b_waddr = 4'd5; b_wdata = 64'h0123456789ABCDEF;
    step();
    b_wen = 1'b0; b_rd_en = 1'b1; b_instruction = ins(21, 5);
    step();
    chk("w64 rs1=21", b_rs1_data, 64'h0123456789ABCDEF);
    chk("w64 rs2=5", b_rs2_data, 64'h0123456789ABCDEF);
    b_rd_en = 1'b0; b_issue_en = 1'b1; b_issue_rd = 4'd5;
    step();
    b_issue_en = 1'b0; b_rd_en = 1'b1; b_instruction = ins(21, 31);
    step();
    chk("w64 busy", {62'h0, b_rs1_busy, b_rs2_busy}, {62'h0, 2'b10});
    chk("w64 x15", b_rs2_data, 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
